// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset vector,
// instruction field widths and the opcode/func values the decoder also uses.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned JIDX_W = 26;
    localparam int unsigned IMM_W  = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FUNC_JR      = 6'h08;
    localparam logic [5:0] FUNC_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNC_ADD     = 6'h20;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: halt > jump-register > jump > taken branch > sequential.
// Purely combinational; the caller only registers the result on an accept.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [31:0]       i_inst,
    input  logic [31:0]       i_rs_value,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_jump_register,
    input  logic              i_halted,
    output logic [ADDR_W-1:0] o_next_pc_c
);

    logic [ADDR_W-1:0] w_jr_target;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_br_offset;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_unused;

    assign w_jr_target = ADDR_W'({i_rs_value[31:2], 2'b00});
    assign w_j_target  = {i_pc_plus4[ADDR_W-1:28], i_inst[JIDX_W-1:0], 2'b00};
    // Word offset: sign-extended immediate scaled by 4, added modulo 2^ADDR_W.
    assign w_br_offset = ADDR_W'({{(32 - IMM_W - 2){i_inst[IMM_W-1]}}, i_inst[IMM_W-1:0], 2'b00});
    assign w_br_target = i_pc_plus4 + w_br_offset;
    assign w_unused    = ^{i_inst[31:JIDX_W], i_rs_value[1:0]};

    always_comb begin
        o_next_pc_c = i_pc_plus4;
        if (i_halted) begin
            o_next_pc_c = i_pc;
        end else if (i_jump_register) begin
            o_next_pc_c = w_jr_target;
        end else if (i_jump) begin
            o_next_pc_c = w_j_target;
        end else if (i_branch) begin
            o_next_pc_c = w_br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack reads from instruction memory, valid/ready
// handoff to decode, and next-PC update from the steering seen at accept.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              branch,
    input  logic              jump,
    input  logic              jump_register,
    input  logic              halted,
    input  logic [31:0]       rs_value,
    output logic              halt_done,
    output logic [31:0]       fetch_count
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic [31:0]       r_inst;
    logic              r_imem_req;
    logic              r_inst_valid;
    logic              r_halt_done;
    logic [31:0]       r_fetch_count;
    logic              r_ack_armed;
    logic [ADDR_W-1:0] w_next_pc;

    next_pc_sel #(
        .ADDR_W(ADDR_W)
    ) u_next_pc_sel (
        .i_pc            (r_pc),
        .i_pc_plus4      (r_pc_plus4),
        .i_inst          (r_inst),
        .i_rs_value      (rs_value),
        .i_branch        (branch),
        .i_jump          (jump),
        .i_jump_register (jump_register),
        .i_halted        (halted),
        .o_next_pc_c     (w_next_pc)
    );

    // r_ack_armed blocks an ack in the same cycle the request first goes high.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pc_plus4    <= RESET_PC + ADDR_W'(4);
            r_inst        <= 32'd0;
            r_imem_req    <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_halt_done   <= 1'b0;
            r_fetch_count <= 32'd0;
            r_ack_armed   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_imem_req  <= 1'b1;
                    r_ack_armed <= 1'b0;
                    r_state     <= S_FETCH;
                end
                S_FETCH: begin
                    if (!r_ack_armed) begin
                        r_ack_armed <= 1'b1;
                    end else if (imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_ack_armed  <= 1'b0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_inst_valid  <= 1'b0;
                        r_pc          <= w_next_pc;
                        r_pc_plus4    <= w_next_pc + ADDR_W'(4);
                        if (halted) begin
                            r_halt_done <= 1'b1;
                            r_state     <= S_HALT;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_halt_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_valid  = r_inst_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign halt_done   = r_halt_done;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model and a small decoder model
// drive the DUT; fetch addresses and issued instructions are queued and checked.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jump_register = 1'b0;
    logic        halted = 1'b0;
    logic [31:0] rs_value = 32'd0;
    logic        halt_done;
    logic [31:0] fetch_count;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch        (branch),
        .jump          (jump),
        .jump_register (jump_register),
        .halted        (halted),
        .rs_value      (rs_value),
        .halt_done     (halt_done),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    iss_t        q_iss[$];
    logic [31:0] q_addr[$];
    logic [31:0] fetched[$];
    logic [31:0] exp_seq [17] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
                                  32'h1C, 32'h20, 32'h1C, 32'h20, 32'h24, 32'h4000_0010,
                                  32'h4000_0100, 32'h1230, 32'hFFFF_FFFC, 32'h1240};

    int          cycle = 0;
    int          req_age = 0;
    int          ack_cycle = 0;
    int          accept_cycle = 0;
    int          last_rise = 0;
    int          exp_count = 0;
    int          stall_left = 0;
    int          beq20_cnt = 0;
    int          halt_ticks = 0;
    int          phase = 1;
    bit          have_accept = 0;
    bit          prev_valid = 0;
    bit          exp_halt = 0;
    bit          halt_chk = 0;
    bit          cnt_pending = 0;
    logic [31:0] rise_addr = 32'd0;
    logic [31:0] stall_pc = 32'd0;

    // Program that walks every steering case and ends in SYSCALL.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] add_w;
        add_w = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FUNC_ADD};
        case (a)
            32'h0, 32'h4, 32'h8, 32'hC,
            32'h10, 32'h14, 32'h18, 32'h1C: mem_rd = add_w;
            32'h20:        mem_rd = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
            32'h24:        mem_rd = {OP_RTYPE, 5'd4, 15'd0, FUNC_JR};
            32'h4000_0010: mem_rd = {OP_J, 26'h000_0040};
            32'h4000_0100: mem_rd = {OP_RTYPE, 5'd5, 15'd0, FUNC_JR};
            32'h1230:      mem_rd = {OP_RTYPE, 5'd6, 15'd0, FUNC_JR};
            32'hFFFF_FFFC: mem_rd = {OP_BNE, 5'd1, 5'd2, 16'h0490};
            32'h1240:      mem_rd = {OP_RTYPE, 20'd0, FUNC_SYSCALL};
            default:       mem_rd = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] rs_for(input logic [31:0] a);
        case (a)
            32'h24:        rs_for = 32'h4000_0013;
            32'h4000_0100: rs_for = 32'h0000_1233;
            32'h1230:      rs_for = 32'hFFFF_FFFF;
            default:       rs_for = $urandom;
        endcase
    endfunction

    task automatic tick();
        iss_t        e;
        logic [31:0] w, rs, p4, npc;
        logic [5:0]  op, fn;
        logic        br, jp, jr, hl;
        int          dly;
        @(negedge clk);
        cycle++;
        if (cnt_pending) begin
            chk("fetch_count", fetch_count, 32'(exp_count));
            cnt_pending = 0;
        end
        if (halt_chk) begin
            chk("halt_done", 32'(halt_done), 32'd1);
            chk("valid_in_halt", 32'(inst_valid), 32'd0);
            halt_chk = 0;
        end
        if (exp_halt) chk("req_after_halt", 32'(imem_req), 32'd0);

        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (req_age == 0) begin
                rise_addr = imem_addr;
                fetched.push_back(imem_addr);
                chk("addr_q_nonempty", 32'(q_addr.size() > 0), 32'd1);
                if (q_addr.size() > 0) chk("fetch_addr", imem_addr, q_addr.pop_front());
                if (have_accept) chk("accept_to_req", cycle, accept_cycle + 1);
                if (phase == 1 && (imem_addr == 32'h4 || imem_addr == 32'h8))
                    chk("throughput", cycle - last_rise, 3);
                last_rise = cycle;
            end else begin
                chk("addr_hold", imem_addr, rise_addr);
                chk("valid_while_fetch", 32'(inst_valid), 32'd0);
            end
            req_age++;
            dly = (rise_addr == 32'h10) ? 5 : 1;
            if (req_age == dly + 1) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_rd(rise_addr);
                ack_cycle  = cycle;
                e.pc       = rise_addr;
                e.inst     = imem_rdata;
                q_iss.push_back(e);
            end else if (req_age == 1 && rise_addr == 32'h10) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
        end else begin
            req_age = 0;
        end

        // Steering is randomised off the accept cycle and must have no effect.
        inst_ready    = 1'b0;
        branch        = 1'($urandom);
        jump          = 1'($urandom);
        jump_register = 1'($urandom);
        halted        = 1'($urandom);
        rs_value      = $urandom;
        if (inst_valid) begin
            if (!prev_valid) chk("ack_to_valid", cycle, ack_cycle + 1);
            chk("iss_q_nonempty", 32'(q_iss.size() > 0), 32'd1);
            if (q_iss.size() > 0) begin
                e = q_iss[0];
                chk("inst", inst, e.inst);
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                if (e.pc == stall_pc && stall_left > 0) begin
                    stall_left--;
                    imem_ack   = 1'b1;
                    imem_rdata = 32'hBAD0_BAD0;
                end else begin
                    void'(q_iss.pop_front());
                    w  = e.inst;
                    op = w[31:26];
                    fn = w[5:0];
                    hl = (op == OP_RTYPE) && (fn == FUNC_SYSCALL);
                    jr = (op == OP_RTYPE) && (fn == FUNC_JR);
                    // SYSCALL also raises jump so halted must win the priority.
                    jp = (op == OP_J) || (op == OP_JAL) || hl;
                    br = ((op == OP_BEQ) || (op == OP_BNE)) && !(e.pc == 32'h20 && beq20_cnt > 0);
                    if (e.pc == 32'h20) beq20_cnt++;
                    rs = rs_for(e.pc);
                    p4 = e.pc + 32'd4;
                    if (hl)      npc = e.pc;
                    else if (jr) npc = {rs[31:2], 2'b00};
                    else if (jp) npc = {p4[31:28], w[25:0], 2'b00};
                    else if (br) npc = p4 + {{14{w[15]}}, w[15:0], 2'b00};
                    else         npc = p4;
                    inst_ready    = 1'b1;
                    branch        = br;
                    jump          = jp;
                    jump_register = jr;
                    halted        = hl;
                    rs_value      = rs;
                    have_accept   = 1;
                    accept_cycle  = cycle;
                    exp_count++;
                    cnt_pending   = 1;
                    if (hl) begin
                        exp_halt = 1;
                        halt_chk = 1;
                    end else begin
                        q_addr.push_back(npc);
                    end
                end
            end
        end
        prev_valid = inst_valid;
    endtask

    task automatic clear_model();
        q_addr.delete();
        q_iss.delete();
        fetched.delete();
        req_age     = 0;
        exp_count   = 0;
        have_accept = 0;
        prev_valid  = 0;
        exp_halt    = 0;
        halt_chk    = 0;
        cnt_pending = 0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
    endtask

    initial begin
        stall_pc   = 32'h8;
        stall_left = 4;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_halt_done", 32'(halt_done), 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        q_addr.push_back(32'h0);
        rst_b = 1'b1;

        for (int i = 0; i < 400 && !(exp_halt && halt_ticks >= 10); i++) begin
            tick();
            if (exp_halt) halt_ticks++;
        end
        chk("halt_reached", 32'(exp_halt), 32'd1);
        chk("stall_consumed", stall_left, 0);
        chk("final_count", fetch_count, 32'd17);
        chk("halt_done_final", 32'(halt_done), 32'd1);
        chk("fetched_len", fetched.size(), 17);
        for (int i = 0; i < 17; i++)
            if (i < fetched.size()) chk($sformatf("seq%0d", i), fetched[i], exp_seq[i]);

        // Second run: stall the first issue, then reset in the middle of a fetch.
        phase = 2;
        rst_b = 1'b0;
        clear_model();
        stall_pc   = 32'h0;
        stall_left = 4;
        q_addr.push_back(32'h0);
        @(negedge clk);
        chk("halt_cleared", 32'(halt_done), 32'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 100 && fetched.size() < 2; i++) tick();
        chk("p2_fetches", fetched.size(), 2);
        chk("p2_stall_consumed", stall_left, 0);
        if (fetched.size() > 1) chk("p2_second_addr", fetched[1], 32'h4);
        chk("p2_req_before_rst", 32'(imem_req), 32'd1);

        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_imem_req", 32'(imem_req), 32'd0);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_fetch_count", fetch_count, 32'd0);
        chk("mid_rst_halt_done", 32'(halt_done), 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        clear_model();
        q_addr.push_back(32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 20 && fetched.size() < 1; i++) tick();
        chk("post_rst_fetch_seen", fetched.size(), 1);
        if (fetched.size() > 0) chk("post_rst_addr", fetched[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
